// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ byte sources. A round-robin
// arbiter picks one requester, latches its byte and the line configuration,
// launches the transmitter with a single-cycle tx_enb, waits for the frame to
// complete (guarded by a watchdog), then acknowledges the requester.
//
// Ports:
//   clk, reset_n        clock; asynchronous reset, active HIGH (reset_n=1)
//   req[NUM_REQ]        level request per requester
//   req_data            requester i byte at [i*DATA_BITS +: DATA_BITS]
//   req_ack[NUM_REQ]    one-hot single-cycle "transfer finished" pulse
//   cfg_ratio           clocks per bit (must be >= 2)
//   cfg_parity_en/odd   parity configuration, latched at grant
//   err_clr             clears the sticky error flags (a new error wins)
//   tx_enb              single-cycle launch pulse to the transmitter
//   tx_data/ratio/...   latched byte and configuration for the transmitter
//   tx_busy, tx_done    transmitter status / frame-complete pulse
//   grant_id            index of the current or last granted requester
//   active              high whenever the FSM is not IDLE
//   timeout_err         sticky: watchdog expired waiting for the transmitter
//   cfg_err             sticky: cfg_ratio < 2 at grant time
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int RATIO_REG_SIZE = 8,
    parameter int TIMEOUT        = 4095
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    input  logic [RATIO_REG_SIZE-1:0]    cfg_ratio,
    input  logic                         cfg_parity_en,
    input  logic                         cfg_parity_odd,
    input  logic                         err_clr,
    output logic                         tx_enb,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic [RATIO_REG_SIZE-1:0]    tx_ratio,
    output logic                         tx_parity_en,
    output logic                         tx_parity_odd,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         active,
    output logic                         timeout_err,
    output logic                         cfg_err
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;

    logic [2:0]       state;
    logic [GID_W-1:0] last_grant;
    logic [WD_W-1:0]  wd_cnt;
    logic             arb_found;
    logic [GID_W-1:0] arb_idx;
    logic             wd_expire;

    // Round-robin search: first set req bit starting just after last_grant.
    always_comb begin : arbitrate
        int               cand_i;
        logic [GID_W-1:0] cand;
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_i    = 0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_i = (int'(last_grant) + off) % NUM_REQ;
            cand   = cand_i[GID_W-1:0];
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // The watchdog has counted TIMEOUT waiting cycles at this edge.
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state         <= S_IDLE;
            // Pointer at the last index so requester 0 wins the first round.
            last_grant    <= GID_W'(NUM_REQ - 1);
            wd_cnt        <= '0;
            grant_id      <= '0;
            tx_data       <= '0;
            tx_ratio      <= '0;
            tx_parity_en  <= 1'b0;
            tx_parity_odd <= 1'b0;
            timeout_err   <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            // Clear first; a set later in this block overrides it (set wins).
            if (err_clr) begin
                timeout_err <= 1'b0;
                cfg_err     <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        grant_id      <= arb_idx;
                        tx_data       <= req_data[int'(arb_idx) * DATA_BITS +: DATA_BITS];
                        tx_ratio      <= cfg_ratio;
                        tx_parity_en  <= cfg_parity_en;
                        tx_parity_odd <= cfg_parity_odd;
                        if (cfg_ratio < RATIO_REG_SIZE'(2)) begin
                            // Transmitter cannot run at this ratio: skip the
                            // launch but still acknowledge the requester.
                            cfg_err <= 1'b1;
                            state   <= S_ACK;
                        end else begin
                            state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (tx_done) begin
                        state <= S_ACK;            // busy phase was missed
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        state       <= S_ACK;
                    end else if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (tx_done) begin
                        state <= S_ACK;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        state       <= S_ACK;
                    end
                end
                S_ACK: begin
                    last_grant <= grant_id;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register.
    assign tx_enb = (state == S_LAUNCH);
    assign active = (state != S_IDLE);

    always_comb begin
        req_ack = '0;
        if (state == S_ACK) req_ack[grant_id] = 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. A main instance (default TIMEOUT) is
// driven by a behavioural transmitter; a second instance with TIMEOUT=100 has
// a transmitter that never finishes unless the bench pulses tx_done itself.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam logic [31:0] D_ALL = 32'h1312_1110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n        = 1'b0;
    logic [3:0] req            = '0;
    logic [31:0] req_data      = '0;
    logic [7:0] cfg_ratio      = 8'd16;
    logic       cfg_parity_en  = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       err_clr        = 1'b0;
    logic       tx_busy        = 1'b0;
    logic       tx_done        = 1'b0;

    logic [3:0] req_ack;
    logic       tx_enb;
    logic [7:0] tx_data;
    logic [7:0] tx_ratio;
    logic       tx_parity_en;
    logic       tx_parity_odd;
    logic [1:0] grant_id;
    logic       active;
    logic       timeout_err;
    logic       cfg_err;

    uart_tx_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .req_ack(req_ack), .cfg_ratio(cfg_ratio), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .err_clr(err_clr), .tx_enb(tx_enb),
        .tx_data(tx_data), .tx_ratio(tx_ratio), .tx_parity_en(tx_parity_en),
        .tx_parity_odd(tx_parity_odd), .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .active(active), .timeout_err(timeout_err),
        .cfg_err(cfg_err)
    );

    // Watchdog instance: its transmitter only finishes when the bench says so.
    logic [3:0] req_w     = '0;
    logic       tx_busy_w = 1'b0;
    logic       tx_done_w = 1'b0;
    logic [3:0] req_ack_w;
    logic       tx_enb_w;
    logic [7:0] tx_data_w;
    logic [7:0] tx_ratio_w;
    logic       tx_parity_en_w;
    logic       tx_parity_odd_w;
    logic [1:0] grant_id_w;
    logic       active_w;
    logic       timeout_err_w;
    logic       cfg_err_w;

    uart_tx_arbiter #(.TIMEOUT(100)) dut_wd (
        .clk(clk), .reset_n(reset_n), .req(req_w), .req_data(D_ALL),
        .req_ack(req_ack_w), .cfg_ratio(cfg_ratio), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .err_clr(err_clr), .tx_enb(tx_enb_w),
        .tx_data(tx_data_w), .tx_ratio(tx_ratio_w), .tx_parity_en(tx_parity_en_w),
        .tx_parity_odd(tx_parity_odd_w), .tx_busy(tx_busy_w), .tx_done(tx_done_w),
        .grant_id(grant_id_w), .active(active_w), .timeout_err(timeout_err_w),
        .cfg_err(cfg_err_w)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural transmitter: normal mode raises busy after the launch and
    // pulses done after 11 bit times; fast mode skips busy and pulses done
    // in the first WAIT_BUSY cycle.
    logic m_fast   = 1'b0;
    int   m_cnt    = 0;
    int   done_cyc = -1;

    always @(negedge clk) begin
        if (reset_n) begin
            tx_busy = 1'b0;
            tx_done = 1'b0;
            m_cnt   = 0;
        end else begin
            tx_done = 1'b0;
            if (tx_enb === 1'b1) begin
                tx_busy = !m_fast;
                m_cnt   = m_fast ? 1 : 11 * int'(tx_ratio);
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    tx_done  = 1'b1;
                    tx_busy  = 1'b0;
                    done_cyc = cyc;
                end
            end
        end
    end

    typedef struct {
        int         launches;
        logic [7:0] data;
        logic [7:0] ratio;
        logic       pen;
        logic       podd;
        logic [3:0] ack;
        logic [1:0] gid;
        bit         held_ok;
        int         ack_cyc;
        int         latency;
    } res_t;

    // Raise req, follow one frame to its ack (bounded), capture what the
    // transmitter was given and whether it stayed stable until the ack.
    task automatic run_frame(input logic [3:0] r, input bit mid_change,
                             input bit drop_req, output res_t res);
        int since;
        int start;
        res = '{launches: 0, data: '0, ratio: '0, pen: 1'b0, podd: 1'b0,
                ack: '0, gid: '0, held_ok: 1'b1, ack_cyc: -1, latency: -1};
        since = -1;
        start = cyc;
        req   = r;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_enb) begin
                res.launches++;
                res.data    = tx_data;
                res.ratio   = tx_ratio;
                res.pen     = tx_parity_en;
                res.podd    = tx_parity_odd;
                res.latency = cyc - start;
                since       = 0;
                if (drop_req) req = '0;
            end else if (since >= 0) begin
                since++;
                if (tx_data !== res.data || tx_ratio !== res.ratio ||
                    tx_parity_en !== res.pen || tx_parity_odd !== res.podd)
                    res.held_ok = 1'b0;
                if (mid_change && since == 5) begin
                    cfg_ratio = 8'd8;
                    req_data  = ~req_data;
                end
            end
            if (req_ack != '0) begin
                res.ack     = req_ack;
                res.gid     = grant_id;
                res.ack_cyc = cyc;
                if (res.launches == 0) begin
                    res.data  = tx_data;
                    res.ratio = tx_ratio;
                    res.pen   = tx_parity_en;
                    res.podd  = tx_parity_odd;
                end
                break;
            end
        end
        req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  ratio;
        logic        pen;
        logic        podd;
        int          exp_launch;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_data;
        logic [3:0]  exp_ack;
        logic        exp_cfg_err;
    } vec_t;

    vec_t vt[8];
    res_t fr;

    logic [7:0] en_data [8];
    logic [3:0] ack_log [8];
    logic [7:0] exp_seq [5];
    logic [3:0] exp_ack_seq [5];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        bit seen;
        int n_en;
        int n_ack;
        int prev;
        int min_gap;

        // Pointer starts at 3, so the search after each ack is hand-derived.
        vt[0] = '{4'b0100, 32'h00A5_0000, 8'd16, 1'b0, 1'b0, 1, 2'd2, 8'hA5, 4'b0100, 1'b0};
        vt[1] = '{4'b0011, D_ALL,         8'd16, 1'b0, 1'b0, 1, 2'd0, 8'h10, 4'b0001, 1'b0};
        vt[2] = '{4'b0011, D_ALL,         8'd4,  1'b1, 1'b0, 1, 2'd1, 8'h11, 4'b0010, 1'b0};
        vt[3] = '{4'b1001, D_ALL,         8'd4,  1'b0, 1'b1, 1, 2'd3, 8'h13, 4'b1000, 1'b0};
        vt[4] = '{4'b1001, D_ALL,         8'd2,  1'b1, 1'b1, 1, 2'd0, 8'h10, 4'b0001, 1'b0};
        vt[5] = '{4'b0001, D_ALL,         8'd1,  1'b0, 1'b0, 0, 2'd0, 8'h10, 4'b0001, 1'b1};
        vt[6] = '{4'b0110, D_ALL,         8'd0,  1'b0, 1'b0, 0, 2'd1, 8'h11, 4'b0010, 1'b1};
        vt[7] = '{4'b1100, D_ALL,         8'd3,  1'b1, 1'b1, 1, 2'd2, 8'h12, 4'b0100, 1'b0};

        // ---- reset values ----
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ack",     32'(req_ack),     32'h0);
        check("rst_tx_enb",      32'(tx_enb),      32'h0);
        check("rst_tx_data",     32'(tx_data),     32'h0);
        check("rst_grant_id",    32'(grant_id),    32'h0);
        check("rst_active",      32'(active),      32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        check("rst_cfg_err",     32'(cfg_err),     32'h0);
        reset_n = 1'b0;
        @(negedge clk);

        // ---- table: single frames, round-robin pointer, cfg latching ----
        for (int i = 0; i < 8; i++) begin
            req_data       = vt[i].data;
            cfg_ratio      = vt[i].ratio;
            cfg_parity_en  = vt[i].pen;
            cfg_parity_odd = vt[i].podd;
            run_frame(vt[i].req, 1'b0, 1'b0, fr);
            check($sformatf("v%0d_launches", i), 32'(fr.launches), 32'(vt[i].exp_launch));
            check($sformatf("v%0d_gid", i),      32'(fr.gid),      32'(vt[i].exp_gid));
            check($sformatf("v%0d_data", i),     32'(fr.data),     32'(vt[i].exp_data));
            check($sformatf("v%0d_ratio", i),    32'(fr.ratio),    32'(vt[i].ratio));
            check($sformatf("v%0d_parity", i),   32'({fr.pen, fr.podd}), 32'({vt[i].pen, vt[i].podd}));
            check($sformatf("v%0d_ack", i),      32'(fr.ack),      32'(vt[i].exp_ack));
            check($sformatf("v%0d_cfg_err", i),  32'(cfg_err),     32'(vt[i].exp_cfg_err));
            check($sformatf("v%0d_held", i),     32'(fr.held_ok),  32'h1);
            if (vt[i].exp_launch != 0) begin
                // tx_enb in the cycle right after the IDLE sampling edge.
                check($sformatf("v%0d_latency", i), 32'(fr.latency), 32'h1);
                check($sformatf("v%0d_ack_after_done", i), 32'(fr.ack_cyc), 32'(done_cyc + 1));
            end
            err_clr = vt[i].exp_cfg_err;
            @(negedge clk);
            err_clr = 1'b0;
            check($sformatf("v%0d_ack_one_cycle", i), 32'(req_ack), 32'h0);
            check($sformatf("v%0d_idle", i),          32'(active),  32'h0);
        end

        // ---- cfg error with err_clr in the same cycle: set wins ----
        cfg_ratio = 8'd1;
        req       = 4'b0001;
        err_clr   = 1'b1;
        @(negedge clk);
        req = '0;
        check("err_set_wins", 32'(cfg_err), 32'h1);
        check("err_ack",      32'(req_ack), 32'b0001);
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", 32'(cfg_err), 32'h0);
        cfg_ratio = 8'd16;
        @(negedge clk);

        // ---- cfg/data changes mid-frame are ignored; next frame uses them ----
        req_data = D_ALL;
        run_frame(4'b0010, 1'b1, 1'b1, fr);
        check("mid_ratio", 32'(fr.ratio),   32'd16);
        check("mid_held",  32'(fr.held_ok), 32'h1);
        check("mid_ack",   32'(fr.ack),     32'b0010);
        @(negedge clk);
        run_frame(4'b0010, 1'b0, 1'b0, fr);
        check("next_ratio", 32'(fr.ratio), 32'd8);
        check("next_data",  32'(fr.data),  32'hEE);
        check("next_ack",   32'(fr.ack),   32'b0010);
        req_data  = D_ALL;
        cfg_ratio = 8'd16;
        @(negedge clk);

        // ---- watchdog (TIMEOUT=100) ----
        req_w = 4'b0001;
        seen  = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = tx_enb_w;
        end
        check("wd_launch", 32'(seen), 32'h1);
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            if (k == 100) begin
                check("wd_not_yet", 32'(timeout_err_w), 32'h0);
                check("wd_waiting", 32'(active_w),      32'h1);
            end
        end
        check("wd_expired", 32'(timeout_err_w), 32'h1);
        check("wd_ack",     32'(req_ack_w),     32'b0001);
        req_w = 4'b0010;
        seen  = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = tx_enb_w;
        end
        check("wd_relaunch", 32'(seen), 32'h1);
        repeat (2) @(negedge clk);
        tx_done_w = 1'b1;
        @(negedge clk);
        tx_done_w = 1'b0;
        req_w     = '0;
        check("wd_served_ack", 32'(req_ack_w),     32'b0010);
        check("wd_sticky",     32'(timeout_err_w), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("wd_cleared", 32'(timeout_err_w), 32'h0);

        // ---- asynchronous reset during WAIT_DONE ----
        req  = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = tx_enb;
        end
        check("rm_launch", 32'(seen), 32'h1);
        repeat (5) @(negedge clk);
        check("rm_busy", 32'(active), 32'h1);
        #2 reset_n = 1'b1;
        #1;
        check("rm_active",   32'(active),   32'h0);
        check("rm_tx_data",  32'(tx_data),  32'h0);
        check("rm_tx_ratio", 32'(tx_ratio), 32'h0);
        check("rm_grant_id", 32'(grant_id), 32'h0);
        check("rm_tx_enb",   32'(tx_enb),   32'h0);
        req = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ack != '0) n_ack++;
        end
        check("rm_no_ack", 32'(n_ack), 32'h0);
        run_frame(4'b0010, 1'b0, 1'b0, fr);
        check("rm_gid",     32'(fr.gid),     32'd1);
        check("rm_latency", 32'(fr.latency), 32'h1);
        check("rm_ack",     32'(fr.ack),     32'b0010);

        // ---- all requesters held: strict order, launch spacing ----
        do_reset();
        m_fast   = 1'b1;
        req_data = D_ALL;
        req      = 4'b1111;
        n_en     = 0;
        n_ack    = 0;
        prev     = -100;
        min_gap  = 1000;
        for (int i = 0; i < 300 && n_ack < 5; i++) begin
            @(negedge clk);
            if (tx_enb) begin
                if (n_en < 8) en_data[n_en] = tx_data;
                if (cyc - prev < min_gap) min_gap = cyc - prev;
                prev = cyc;
                n_en++;
            end
            if (req_ack != '0) begin
                if (n_ack < 8) ack_log[n_ack] = req_ack;
                n_ack++;
            end
        end
        req    = '0;
        m_fast = 1'b0;
        exp_seq     = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp_ack_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("rr_launches", 32'(n_en),  32'd5);
        check("rr_acks",     32'(n_ack), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_data%0d", i), 32'(en_data[i]), 32'(exp_seq[i]));
            check($sformatf("rr_ack%0d", i),  32'(ack_log[i]), 32'(exp_ack_seq[i]));
        end
        check("rr_min_gap_ge4", 32'(min_gap >= 4), 32'h1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte sources using round-robin arbitration.
- Latches one requester's byte and the global line configuration, launches the transmitter with a single-cycle enable, waits for frame completion, then acknowledges that requester.
- Sits between the system's byte producers (debug, status, console) and the single UART TX datapath.
- Includes a watchdog and a configuration check, so a stuck or misconfigured transmitter never hangs the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, bits per character.
- RATIO_REG_SIZE, 8, width of the clocks-per-bit ratio.
- TIMEOUT, 4095, maximum cycles to wait for the transmitter per frame; the watchdog counter is $clog2(TIMEOUT+1) bits wide.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- req  in  NUM_REQ  per-requester transfer request, level.
- req_data  in  NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS].
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse: requester's transfer finished.
- cfg_ratio  in  RATIO_REG_SIZE  clocks per bit.
- cfg_parity_en  in  1  parity enable.
- cfg_parity_odd  in  1  parity select, passed through unchanged.
- err_clr  in  1  clears the sticky error flags.
- tx_enb  out  1  launch pulse to the transmitter.
- tx_data  out  DATA_BITS  byte to transmit.
- tx_ratio  out  RATIO_REG_SIZE  latched ratio.
- tx_parity_en  out  1  latched parity enable.
- tx_parity_odd  out  1  latched parity select.
- tx_busy  in  1  transmitter busy.
- tx_done  in  1  transmitter frame-complete pulse.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- active  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  sticky: watchdog expired.
- cfg_err  out  1  sticky: ratio below 2 at grant time.

Behaviour:
- Reset: reset_n, asynchronous, active-high; clock clk. While reset_n=1 the block is held in reset.
  - Reset values: all outputs 0; state IDLE; priority pointer such that requester 0 wins first; watchdog counter 0.
- Registered FSM with states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE:
  - If any req bit is high, choose the first set bit searching from (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - Latch that requester's byte into tx_data, latch cfg_* into tx_*, and set grant_id.
  - If cfg_ratio < 2: set cfg_err and go to ACK without launching.
  - Otherwise go to LAUNCH.
- LAUNCH: tx_enb=1 for exactly this one cycle; clear the watchdog; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - tx_done=1 (busy was missed) -> ACK.
- WAIT_DONE: tx_done=1 -> ACK.
- Watchdog:
  - Counts every cycle in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT: set timeout_err and go to ACK.
- ACK:
  - Pulse req_ack[grant_id] for one cycle and set last_grant=grant_id.
  - Go to IDLE. Earliest re-arbitration is the next cycle, so there are at least 2 idle cycles between tx_enb pulses.
- Latency: req rising while IDLE -> tx_enb high 2 cycles later (IDLE sample, LAUNCH).
- tx_data and tx_* hold their values from grant through ACK. Changes to cfg_* or req_data mid-frame have no effect.
- Requester rules:
  - Hold req high and req_data stable until req_ack.
  - Deasserting req after grant does not abort the frame; ack still pulses.
  - req deasserted before grant: not served.
  - req held high after ack: treated as a new request, but arbitration skips to the other requesters first.
- Error flags:
  - timeout_err and cfg_err stay set until err_clr=1.
  - If err_clr and a new error occur in the same cycle, set wins.
- Single requester: served back-to-back with no starvation check.
- All requesters active: served strictly in order 0,1,2,3,0,...
- tx_done in IDLE or LAUNCH is ignored.
- Reset mid-frame: the FSM returns immediately to IDLE, tx_enb drops, and no ack is issued.

Test Plan:
1. Only req[2]=1, data 0xA5, ratio 16, transmitter model with busy next cycle and done after 11 bits -> exactly one tx_enb with tx_data=0xA5; req_ack=4'b0100 one cycle after done; grant_id=2.
2. req=4'b1111 held with distinct bytes 0x10..0x13 -> tx_data sequence 0x10,0x11,0x12,0x13,0x10; acks in the same order; never two tx_enb within 3 cycles.
3. cfg_ratio changes 16->8 mid-frame -> tx_ratio stays 16 until ACK; the next frame uses 8.
4. cfg_ratio=1 with req[0] -> no tx_enb, cfg_err=1, req_ack[0] pulses; err_clr=1 clears cfg_err next cycle.
5. Transmitter model never asserts done, TIMEOUT=100 -> timeout_err=1 exactly 100 cycles after entering WAIT_BUSY; ack pulses; the next request is still served.
6. reset_n pulsed high during WAIT_DONE -> outputs 0 asynchronously, no ack; after release, req[1] is granted from IDLE normally.
